sprinkler_scheduler_n: RTL and testbench

- Parametrised multi-zone sprinkler scheduler. It periodically scans a schedule stored on the SD card, one line per entry, and compares each entry's window with GPS time-of-day.
- It drives NUM_ZONES valve enables, updated atomically at the end of each scan.
- It adds an SD read handshake with timeout, midnight-wrapping windows, a rain hold-off and GPS-validity gating.
- It sits between the GPS, rain sensor and SD reader blocks and the zone valve drivers.

---
 rtl/sprinkler_scheduler_n.sv | 213 +++++++++++++++++++++
 tb/tb_sprinkler_scheduler_n.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprinkler_scheduler_n.sv
// Multi-zone sprinkler scheduler. Periodically scans LINE_NUMBER schedule lines from the SD
// reader, matches each window (midnight wrap allowed) against GPS time-of-day and commits the
// resulting valve mask atomically. Rain forces valves off for RAIN_HOLDOFF further scans.
// Optional macro MANUAL_OVERRIDE_EN adds manual_en/manual_mask to force the valve outputs.
module sprinkler_scheduler_n #(
  parameter int unsigned NUM_ZONES    = 8,
  parameter int unsigned ZONE_W       = 3,
  parameter int unsigned TIME_W       = 17,
  parameter int unsigned DAY_END      = 86400,
  parameter int unsigned TCLK         = 10,
  parameter int unsigned INSP_PERIOD  = 600,
  parameter int unsigned LINE_NUMBER  = 4,
  parameter int unsigned SD_TIMEOUT   = 255,
  parameter int unsigned RAIN_HOLDOFF = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TIME_W-1:0]    gps_time_reg,
  input  logic                 gps_data_valid,
  input  logic                 raining,
  output logic                 sd_read_next_line,
  input  logic                 sd_data_valid,
  input  logic [ZONE_W-1:0]    sd_zones,
  input  logic [TIME_W-1:0]    sd_start_time,
  input  logic [TIME_W-1:0]    sd_stop_time,
`ifdef MANUAL_OVERRIDE_EN
  input  logic                 manual_en,
  input  logic [NUM_ZONES-1:0] manual_mask,
`endif
  output logic [NUM_ZONES-1:0] zones,
  output logic                 scan_busy,
  output logic                 sd_error,
  output logic                 rain_hold
);

  localparam int unsigned TimerW = $clog2(INSP_PERIOD + TCLK + 1);
  localparam int unsigned LineW  = $clog2(LINE_NUMBER + 1);
  localparam int unsigned WaitW  = $clog2(SD_TIMEOUT + 1);
  localparam int unsigned HoldW  = (RAIN_HOLDOFF > 0) ? $clog2(RAIN_HOLDOFF + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StReq,
    StCap,
    StEval,
    StCommit
  } state_e;

  state_e                state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [LineW-1:0]      line_q, line_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic [NUM_ZONES-1:0]  shadow_q, shadow_d;
  logic [NUM_ZONES-1:0]  sched_q, sched_d;
  logic                  rain_seen_q, rain_seen_d;
  logic                  sd_error_q, sd_error_d;
  logic [ZONE_W-1:0]     zone_q, zone_d;
  logic [TIME_W-1:0]     start_q, start_d;
  logic [TIME_W-1:0]     stop_q, stop_d;
  logic                  entry_active;

  // Window match for the captured line; start == stop never matches.
  always_comb begin
    entry_active = 1'b0;
    if ((32'(start_q) < DAY_END) && (32'(stop_q) < DAY_END)) begin
      if (start_q < stop_q) begin
        entry_active = (gps_time_reg >= start_q) && (gps_time_reg < stop_q);
      end else if (start_q > stop_q) begin
        entry_active = (gps_time_reg >= start_q) || (gps_time_reg < stop_q);
      end
    end
  end

  // Scan FSM next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    line_d      = line_q;
    wait_d      = wait_q;
    hold_d      = hold_q;
    shadow_d    = shadow_q;
    sched_d     = sched_q;
    rain_seen_d = rain_seen_q;
    sd_error_d  = 1'b0;
    zone_d      = zone_q;
    start_d     = start_q;
    stop_d      = stop_q;
    case (state_q)
      StIdle: begin
        if (timer_q >= TimerW'(INSP_PERIOD)) begin
          timer_d = '0;
          state_d = StStart;
        end else begin
          timer_d = timer_q + TimerW'(TCLK);
        end
      end
      StStart: begin
        if (!gps_data_valid) begin
          state_d = StIdle;
        end else begin
          shadow_d    = '0;
          line_d      = '0;
          wait_d      = '0;
          rain_seen_d = raining;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (sd_data_valid) begin
          zone_d  = sd_zones;
          start_d = sd_start_time;
          stop_d  = sd_stop_time;
          wait_d  = '0;
          state_d = StCap;
        end else if (wait_q + WaitW'(1) == WaitW'(SD_TIMEOUT)) begin
          // Abandon the scan; committed zones and hold-off stay as they were.
          sd_error_d = 1'b1;
          state_d    = StIdle;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StCap: begin
        state_d = StEval;
      end
      StEval: begin
        rain_seen_d = rain_seen_q | raining;
        if (entry_active) begin
          for (int unsigned i = 0; i < NUM_ZONES; i++) begin
            if (32'(zone_q) == i) begin
              shadow_d[i] = 1'b1;
            end
          end
        end
        line_d = line_q + LineW'(1);
        if (line_q + LineW'(1) < LineW'(LINE_NUMBER)) begin
          state_d = StReq;
        end else begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        if (rain_seen_q) begin
          hold_d = HoldW'(RAIN_HOLDOFF);
        end else if (hold_q != '0) begin
          hold_d = hold_q - HoldW'(1);
        end
        // Hold-off is judged on the value before this scan's update.
        sched_d = (rain_seen_q || (hold_q != '0)) ? '0 : shadow_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      line_q      <= '0;
      wait_q      <= '0;
      hold_q      <= '0;
      shadow_q    <= '0;
      sched_q     <= '0;
      rain_seen_q <= 1'b0;
      sd_error_q  <= 1'b0;
      zone_q      <= '0;
      start_q     <= '0;
      stop_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      line_q      <= line_d;
      wait_q      <= wait_d;
      hold_q      <= hold_d;
      shadow_q    <= shadow_d;
      sched_q     <= sched_d;
      rain_seen_q <= rain_seen_d;
      sd_error_q  <= sd_error_d;
      zone_q      <= zone_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
    end
  end

  assign sd_read_next_line = (state_q == StReq);
  assign scan_busy         = (state_q != StIdle);
  assign sd_error          = sd_error_q;
  assign rain_hold         = (hold_q != '0);

`ifdef MANUAL_OVERRIDE_EN
  logic [NUM_ZONES-1:0] zones_q;

  // Output register: manual mask wins; otherwise track the committed schedule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zones_q <= '0;
    end else begin
      zones_q <= manual_en ? manual_mask : sched_d;
    end
  end

  assign zones = zones_q;
`else
  assign zones = sched_q;
`endif

endmodule

// File: tb/tb_sprinkler_scheduler_n.sv
// Scoreboard bench for sprinkler_scheduler_n: stimulus pushes the modelled outcome of each
// scan, a monitor pops and compares whenever a scan ends.
module tb_sprinkler_scheduler_n;

  localparam int N   = 6;
  localparam int ZW  = 3;
  localparam int TW  = 17;
  localparam int L   = 4;
  localparam int TO  = 255;
  localparam int HO  = 3;
  localparam int GAP = 600 / 10 + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] gps_time_reg = '0;
  logic          gps_data_valid = 1'b0;
  logic          raining = 1'b0;
  logic          sd_read_next_line;
  logic          sd_data_valid = 1'b0;
  logic [ZW-1:0] sd_zones = '0;
  logic [TW-1:0] sd_start_time = '0;
  logic [TW-1:0] sd_stop_time = '0;
  logic [N-1:0]  zones;
  logic          scan_busy;
  logic          sd_error;
  logic          rain_hold;
`ifdef MANUAL_OVERRIDE_EN
  logic          manual_en = 1'b0;
  logic [N-1:0]  manual_mask = '0;
`endif

  always #5 clk = ~clk;

  sprinkler_scheduler_n #(
    .NUM_ZONES   (N),
    .ZONE_W      (ZW),
    .TIME_W      (TW),
    .DAY_END     (86400),
    .TCLK        (10),
    .INSP_PERIOD (600),
    .LINE_NUMBER (L),
    .SD_TIMEOUT  (TO),
    .RAIN_HOLDOFF(HO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .gps_time_reg     (gps_time_reg),
    .gps_data_valid   (gps_data_valid),
    .raining          (raining),
    .sd_read_next_line(sd_read_next_line),
    .sd_data_valid    (sd_data_valid),
    .sd_zones         (sd_zones),
    .sd_start_time    (sd_start_time),
    .sd_stop_time     (sd_stop_time),
`ifdef MANUAL_OVERRIDE_EN
    .manual_en        (manual_en),
    .manual_mask      (manual_mask),
`endif
    .zones            (zones),
    .scan_busy        (scan_busy),
    .sd_error         (sd_error),
    .rain_hold        (rain_hold)
  );

  typedef struct {
    logic [N-1:0] zones;
    logic         hold;
    logic         err;
    int           busy;
    int           reqs;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           stray_err = 0;
  logic [N-1:0] m_zones = '0;
  int           m_hold = 0;
  int           ln_z[L];
  int           ln_s[L];
  int           ln_e[L];
  int           ln_w[L];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit in_window(input int t, input int s, input int e);
    if (s < e) return (t >= s) && (t < e);
    if (s > e) return (t >= s) || (t < e);
    return 1'b0;
  endfunction

  task automatic set_line(input int i, input int z, input int s, input int e, input int w);
    ln_z[i] = z;
    ln_s[i] = s;
    ln_e[i] = e;
    ln_w[i] = w;
  endtask

  task automatic wait_busy(input logic level, input int limit, input string name);
    int n = 0;
    while (scan_busy !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (scan_busy !== level) begin
      checks++;
      errors++;
      $display("FAIL %s: scan_busy stuck at %0b, wanted %0b", name, scan_busy, level);
    end
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!sd_read_next_line && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = sd_read_next_line;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL sd_request: request never rose");
    end
  endtask

  // Serve one line after its programmed wait; sometimes leave a stray valid during capture.
  task automatic serve_line(input int i, input bit rain_now);
    bit ok;
    wait_req(ok);
    if (ok) begin
      repeat (ln_w[i]) @(negedge clk);
      if (rain_now) raining = 1'b1;
      sd_zones      = ZW'(ln_z[i]);
      sd_start_time = TW'(ln_s[i]);
      sd_stop_time  = TW'(ln_e[i]);
      sd_data_valid = 1'b1;
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        sd_zones      = ZW'($urandom_range(0, N - 1));
        sd_start_time = '0;
        sd_stop_time  = TW'(86399);
        @(negedge clk);
      end
      sd_data_valid = 1'b0;
    end
  endtask

  // rain_line: -2 dry, -1 raining at start, k raised while serving line k.
  task automatic run_scan(input int t, input bit gps, input int rain_line, input int to_line);
    exp_t         x;
    logic [N-1:0] shadow;
    int           prev;
    bit           rain;
    bit           ok;
    int           n;
    x.zones = m_zones;
    x.hold  = (m_hold != 0);
    x.err   = 1'b0;
    x.busy  = 1;
    x.reqs  = 0;
    if (gps && to_line >= 0) begin
      x.err  = 1'b1;
      x.reqs = to_line + 1;
      x.busy = 1 + TO;
      for (int i = 0; i < to_line; i++) x.busy += 3 + ln_w[i];
    end else if (gps) begin
      rain   = (rain_line >= -1);
      shadow = '0;
      for (int i = 0; i < L; i++) begin
        if (ln_z[i] < N && in_window(t, ln_s[i], ln_e[i])) shadow[ln_z[i]] = 1'b1;
      end
      prev    = m_hold;
      m_hold  = rain ? HO : ((m_hold > 0) ? m_hold - 1 : 0);
      m_zones = (rain || prev != 0) ? '0 : shadow;
      x.zones = m_zones;
      x.hold  = (m_hold != 0);
      x.reqs  = L;
      x.busy  = 2 + 3 * L;
      for (int i = 0; i < L; i++) x.busy += ln_w[i];
    end
    gps_time_reg   = TW'(t);
    gps_data_valid = gps;
    if (rain_line == -1) raining = 1'b1;
    exp_q.push_back(x);
    wait_busy(1'b1, 200, "scan_start");
    if (gps) begin
      for (int i = 0; i < L; i++) begin
        if (i == to_line) begin
          wait_req(ok);
          n = 0;
          while (ok && !sd_error && n < 300) begin
            @(negedge clk);
            n++;
          end
          chk("sd_error_delay", n, TO);
          chk("idle_after_timeout", int'(scan_busy), 0);
          break;
        end
        serve_line(i, rain_line == i);
      end
    end
    wait_busy(1'b0, 400, "scan_end");
    raining = 1'b0;
  endtask

  // Monitor: compares each finished scan against the scoreboard.
  initial begin
    logic prev_busy = 1'b0;
    logic prev_req  = 1'b0;
    bit   first     = 1'b1;
    int   busy_cnt  = 0;
    int   req_cnt   = 0;
    int   idle_cnt  = 0;
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        prev_req  = 1'b0;
        first     = 1'b1;
        busy_cnt  = 0;
        req_cnt   = 0;
        idle_cnt  = 0;
        continue;
      end
      if (sd_error && !(prev_busy && !scan_busy)) stray_err++;
      if (scan_busy && !prev_busy) begin
        if (!first) chk("idle_gap", idle_cnt, GAP);
        first    = 1'b0;
        busy_cnt = 0;
        req_cnt  = 0;
      end
      if (scan_busy) begin
        busy_cnt++;
        if (sd_read_next_line && !prev_req) req_cnt++;
      end else if (prev_busy) begin
        idle_cnt = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: scan ended with nothing expected");
        end else begin
          x = exp_q.pop_front();
          chk("zones", int'(zones), int'(x.zones));
          chk("rain_hold", int'(rain_hold), int'(x.hold));
          chk("sd_error", int'(sd_error), int'(x.err));
          chk("busy_cycles", busy_cnt, x.busy);
          chk("requests", req_cnt, x.reqs);
        end
      end else begin
        idle_cnt++;
      end
      prev_req  = sd_read_next_line;
      prev_busy = scan_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int rl;
    int tl;
    bit g;
    repeat (2) @(negedge clk);
    chk("reset_zones", int'(zones), 0);
    chk("reset_busy", int'(scan_busy), 0);
    chk("reset_req", int'(sd_read_next_line), 0);
    chk("reset_hold", int'(rain_hold), 0);
    rst = 1'b0;

    // Basic windows plus out-of-range zone 7.
    set_line(0, 2, 3000, 4000, 0);
    set_line(1, 5, 5000, 6000, 0);
    set_line(2, 3, 7, 7, 0);
    set_line(3, 7, 0, 86399, 0);
    run_scan(3600, 1'b1, -2, -1);
    // Midnight wrap and empty window.
    set_line(0, 0, 86000, 500, 0);
    set_line(1, 1, 1000, 1000, 0);
    set_line(2, 6, 0, 86399, 1);
    set_line(3, 7, 50, 200, 2);
    run_scan(100, 1'b1, -2, -1);
    run_scan(600, 1'b1, -2, -1);
    // Rain on the second line, then hold-off scans.
    set_line(0, 0, 3000, 4000, 0);
    set_line(1, 1, 86000, 4000, 0);
    set_line(2, 2, 0, 86399, 0);
    set_line(3, 3, 3600, 3601, 0);
    run_scan(3600, 1'b1, 1, -1);
    for (int k = 0; k < 4; k++) run_scan(3600, 1'b1, -2, -1);
    // SD timeout on the third line, then GPS invalid.
    run_scan(3600, 1'b1, -2, 2);
    run_scan(3600, 1'b1, -1, -1);
    run_scan(3600, 1'b0, -1, -1);

    // Async reset while requesting.
    begin
      bit ok;
      gps_data_valid = 1'b1;
      wait_busy(1'b1, 200, "reset_scan_start");
      wait_req(ok);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_zones", int'(zones), 0);
      chk("rst_mid_req", int'(sd_read_next_line), 0);
      chk("rst_mid_busy", int'(scan_busy), 0);
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      m_zones = '0;
      m_hold  = 0;
    end

    for (int k = 0; k < 30; k++) begin
      t = $urandom_range(0, 86399);
      for (int i = 0; i < L; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          set_line(i, $urandom_range(0, 7), $urandom_range(0, 86399),
                   $urandom_range(0, 86399), $urandom_range(0, 3));
        end else begin
          set_line(i, $urandom_range(0, 7), (t + 86400 - $urandom_range(0, 2000)) % 86400,
                   (t + $urandom_range(0, 2000)) % 86400, $urandom_range(0, 3));
        end
      end
      rl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, L) - 1 : -2;
      tl = ($urandom_range(0, 15) == 0) ? $urandom_range(0, L - 1) : -1;
      g  = ($urandom_range(0, 15) != 0);
      run_scan(t, g, rl, tl);
    end

`ifdef MANUAL_OVERRIDE_EN
    manual_mask = 6'b101010;
    manual_en   = 1'b1;
    raining     = 1'b1;
    @(negedge clk);
    chk("manual_zones", int'(zones), 'b101010);
    manual_en = 1'b0;
    raining   = 1'b0;
    @(negedge clk);
    chk("manual_release", int'(zones), int'(m_zones));
`endif

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("scoreboard_drained", exp_q.size(), 0);
    end
    chk("stray_sd_error", stray_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
